// File: rtl/mc_pkg.sv
// ============================================================================
// Module      : mc_pkg
// Description : Shared types, opcodes and select encodings for the multicycle
//               RV32I control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       adr_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       pc_update;
        logic       branch;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctl_t;

    // Moore control word for a state; anything not set stays 0.
    function automatic ctl_t state_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
            end
            DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_write  = 1'b1;
            end
            EXECR: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_WD;
                c.alu_op    = ALUOP_FUNCT;
            end
            EXECI: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            BEQ: begin
                c.alu_src_a  = SRCA_A;
                c.alu_src_b  = SRCB_WD;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_alu_decoder.sv
// ============================================================================
// Module      : alu_decoder
// Description : Maps alu_op plus funct fields to the 3-bit ALU operation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module      : multicycle_controller
// Description : Moore FSM control unit for the multicycle RV32I datapath.
//               Optional memory handshake enabled by MC_MEM_READY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
`ifdef MC_MEM_READY_EN
    input  logic       mem_ready,
`endif
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal_op
);

    state_t r_state;
    state_t w_next;
    ctl_t   r_ctl;
    logic   w_ready;
    logic   w_op_legal;
    logic   w_fetch_ok;

`ifdef MC_MEM_READY_EN
    assign w_ready = mem_ready;
`else
    assign w_ready = 1'b1;
`endif

    assign w_op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                        (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:    if (w_ready) w_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_R:         w_next = EXECR;
                    OP_I:         w_next = EXECI;
                    OP_BEQ:       w_next = BEQ;
                    OP_JAL:       w_next = JAL;
                    default:      w_next = FETCH;
                endcase
            end
            MEMADR:   w_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (w_ready) w_next = MEMWB;
            MEMWB:    w_next = FETCH;
            MEMWRITE: if (w_ready) w_next = FETCH;
            EXECR:    w_next = ALUWB;
            EXECI:    w_next = ALUWB;
            ALUWB:    w_next = FETCH;
            BEQ:      w_next = FETCH;
            JAL:      w_next = ALUWB;
            default:  w_next = FETCH;
        endcase
    end

    // Control word is registered against the next state so outputs come
    // straight from flops; reset parks it on the FETCH word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_ctl   <= state_ctl(FETCH);
        end else begin
            r_state <= w_next;
            r_ctl   <= state_ctl(w_next);
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (r_ctl.alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

    // Fetch-side enables wait for the memory; other states ignore mem_ready.
    assign w_fetch_ok = (r_state != FETCH) || w_ready;

    assign pc_write   = rst_n & ((r_ctl.pc_update & w_fetch_ok) | (r_ctl.branch & zero));
    assign ir_write   = rst_n & r_ctl.ir_write & w_fetch_ok;
    assign mem_write  = rst_n & r_ctl.mem_write;
    assign reg_write  = rst_n & r_ctl.reg_write;
    assign illegal_op = rst_n & (r_state == DECODE) & ~w_op_legal;

    assign adr_src    = r_ctl.adr_src;
    assign result_src = r_ctl.result_src;
    assign alu_src_a  = r_ctl.alu_src_a;
    assign alu_src_b  = r_ctl.alu_src_b;

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_BEQ:  imm_src = IMM_B;
            OP_SW:   imm_src = IMM_S;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for multicycle_controller against a
//               per-instruction cycle model. Honours MC_MEM_READY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    int n_vec;
    int n_err;
    int zero_sel;
    int stall_cyc;
    int stall_left;
    int rnd_ready;
    int mw_cycles;

    multicycle_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
`ifdef MC_MEM_READY_EN
        .mem_ready   (mem_ready),
`endif
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .imm_src     (imm_src),
        .reg_write   (reg_write),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction classes: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 illegal
    function automatic int kind_of(input logic [6:0] o);
        case (o)
            7'b0000011: return 0;
            7'b0100011: return 1;
            7'b0110011: return 2;
            7'b0010011: return 3;
            7'b1100011: return 4;
            7'b1101111: return 5;
            default:    return 6;
        endcase
    endfunction

    function automatic int cpi_of(input int k);
        case (k)
            0: return 5;
            1, 2, 3, 5: return 4;
            4: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (kind_of(o))
            1: return 2'b01;
            4: return 2'b10;
            5: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] funct_ctl(input logic [2:0] f3, input logic is_r, input logic f7);
        case (f3)
            3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic stalls(input int k, input int cyc);
        return (cyc == 0) || (cyc == 3 && (k == 0 || k == 1));
    endfunction

    // Expected {pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op,
    //           result_src, alu_src_a, alu_src_b, alu_control, imm_src}
    function automatic logic [16:0] model(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z,
                                          input int cyc, input logic rdy);
        logic       pcw, adr, mw, irw, rw, ill;
        logic [1:0] res, a, b;
        logic [2:0] ctl;
        int         k;
        k = kind_of(o);
        {pcw, adr, mw, irw, rw, ill} = 6'b0;
        res = 2'b00; a = 2'b00; b = 2'b00; ctl = 3'b000;
        if (cyc == 0) begin
            irw = rdy; pcw = rdy; b = 2'b10; res = 2'b10;
        end else if (cyc == 1) begin
            a = 2'b01; b = 2'b01; ill = (k == 6);
        end else begin
            case (k)
                0, 1: begin
                    if (cyc == 2) begin a = 2'b10; b = 2'b01; end
                    else if (cyc == 3) begin adr = 1'b1; mw = (k == 1); end
                    else begin res = 2'b01; rw = 1'b1; end
                end
                2, 3: begin
                    if (cyc == 2) begin
                        a = 2'b10; b = (k == 2) ? 2'b00 : 2'b01;
                        ctl = funct_ctl(f3, k == 2, f7);
                    end else rw = 1'b1;
                end
                4: begin a = 2'b10; ctl = 3'b001; pcw = z; end
                5: begin
                    if (cyc == 2) begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
                    else rw = 1'b1;
                end
                default: ;
            endcase
        end
        return {pcw, adr, mw, irw, rw, ill, res, a, b, ctl, imm_of(o)};
    endfunction

    function automatic logic [16:0] observed();
        return {pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op,
                result_src, alu_src_a, alu_src_b, alu_control, imm_src};
    endfunction

    // Runs one instruction from FETCH, checking every cycle. Entered just
    // after a falling edge; stops early (without advancing) when cyc==stop.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input int stop, input string name);
        int          k, cyc, guard;
        logic        rdy;
        logic [16:0] exp_v, got_v;
        k = kind_of(o); cyc = 0; guard = 0; mw_cycles = 0;
        while (cyc < cpi_of(k) && guard < 64) begin
            op = o; funct3 = f3; funct7b5 = f7;
            zero = (zero_sel < 0) ? 1'($urandom_range(0, 1)) : zero_sel[0];
            rdy = 1'b1;
`ifdef MC_MEM_READY_EN
            if (stalls(k, cyc)) begin
                if (cyc == stall_cyc && stall_left > 0) begin
                    rdy = 1'b0; stall_left--;
                end else if (rnd_ready != 0) rdy = 1'($urandom_range(0, 1));
            end
`endif
            mem_ready = rdy;
            #1;
            exp_v = model(o, f3, f7, zero, cyc, rdy);
            got_v = observed();
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL %s op=%b cyc=%0d got=%b exp=%b", name, o, cyc, got_v, exp_v);
            end
            if (mem_write === 1'b1) mw_cycles++;
            if (cyc == stop) return;
            @(negedge clk);
            if (!stalls(k, cyc) || rdy) cyc++;
            guard++;
        end
        if (guard >= 64) begin
            n_err++;
            $display("FAIL %s timeout got=%0d cycles exp<64", name, guard);
        end
    endtask

    task automatic check_reset_vec(input string name);
        logic [16:0] exp_v;
        exp_v = {6'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm_of(op)};
        n_vec++;
        if (observed() !== exp_v) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b", name, observed(), exp_v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        zero = 1'b1; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1 check_reset_vec("reset_state");
        rst_n = 1'b1;
        run_instr(7'b0000011, 3'b010, 1'b0, -1, "first_after_reset");
    endtask

    task automatic test_lw();
        run_instr(7'b0000011, 3'b010, 1'b0, -1, "lw");
    endtask

    task automatic test_r_vs_i();
        run_instr(7'b0110011, 3'b000, 1'b1, -1, "r_sub");
        run_instr(7'b0010011, 3'b000, 1'b1, -1, "i_add");
        run_instr(7'b0110011, 3'b111, 1'b0, -1, "r_and");
        run_instr(7'b0010011, 3'b010, 1'b0, -1, "i_slt");
    endtask

    task automatic test_beq();
        zero_sel = 1;
        run_instr(7'b1100011, 3'b000, 1'b0, -1, "beq_taken");
        zero_sel = 0;
        run_instr(7'b1100011, 3'b000, 1'b0, -1, "beq_not_taken");
        zero_sel = -1;
    endtask

    task automatic test_jal_illegal();
        run_instr(7'b1101111, 3'b000, 1'b0, -1, "jal");
        run_instr(7'b1111111, 3'b000, 1'b0, -1, "illegal");
        run_instr(7'b0100011, 3'b010, 1'b0, -1, "sw");
    endtask

    task automatic test_reset_mid_exec();
        run_instr(7'b0110011, 3'b110, 1'b0, 2, "pre_reset_execr");
        rst_n = 1'b0;
        #1 check_reset_vec("reset_mid_execr");
        @(negedge clk);
        @(negedge clk);
        #1 check_reset_vec("reset_held");
        rst_n = 1'b1;
        run_instr(7'b0010011, 3'b111, 1'b0, -1, "restart_after_reset");
    endtask

    task automatic test_random();
        logic [6:0] o;
        logic [6:0] ops [6];
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
        rnd_ready = 1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 6) == 0) begin
                o = 7'($urandom_range(0, 127));
                while (kind_of(o) != 6) o = 7'($urandom_range(0, 127));
            end else o = ops[$urandom_range(0, 5)];
            run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, "random");
        end
        rnd_ready = 0;
    endtask

    task automatic test_mem_ready();
`ifdef MC_MEM_READY_EN
        stall_cyc = 3; stall_left = 3;
        run_instr(7'b0100011, 3'b010, 1'b0, -1, "sw_stall");
        n_vec++;
        if (mw_cycles != 4) begin
            n_err++;
            $display("FAIL sw_stall_mem_write_cycles got=%0d exp=4", mw_cycles);
        end
        stall_cyc = 0; stall_left = 2;
        run_instr(7'b0110011, 3'b000, 1'b0, -1, "fetch_stall");
        stall_left = 0;
`endif
    endtask

    initial begin
        n_vec = 0; n_err = 0; zero_sel = -1;
        stall_cyc = -1; stall_left = 0; rnd_ready = 0; mw_cycles = 0;
        test_reset();
        test_lw();
        test_r_vs_i();
        test_beq();
        test_jal_illegal();
        test_reset_mid_exec();
        test_mem_ready();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
